// File: rtl/bcd_2_bin_seq.sv
// Sequential BCD-to-binary converter: acc = acc*10 + digit, MSD first, one digit per clock.
// Latency: done after DIGITS clocks from the accepting edge; a bad digit is reported on the sampling edge.
// Backpressure: none; start is ignored while busy, and a new start is accepted in the done cycle.
module bcd_2_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10   // must hold 10^DIGITS - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [4*DIGITS-1:0]  bcd_q;
    logic [BIN_W-1:0]     acc_q;
    logic [BIN_W-1:0]     acc_nxt;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIN_W-1:0]     bin_q;
    logic                 err_q;
    logic                 done_q;
    logic [3:0]           cur_digit;
    logic                 bad_digit;
    logic                 accept;
    logic                 reject;
    logic                 last;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == i[CNT_W-1:0]) begin
                cur_digit = bcd_q[4*i +: 4];
            end
        end
    end

    assign accept  = (state_q == IDLE) && start && !bad_digit;
    assign reject  = (state_q == IDLE) && start &&  bad_digit;
    assign last    = (state_q == CONV) && (cnt_q == '0);
    // acc*10 built from shifts so it maps onto two adders rather than a multiplier
    assign acc_nxt = (acc_q << 3) + (acc_q << 1) + BIN_W'(cur_digit);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CONV;
            CONV:    if (last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q == CONV);
    end

    // Datapath: operand latch, accumulator, digit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                bcd_q <= bcd;
                acc_q <= '0;
                cnt_q <= CNT_W'(DIGITS - 1);
                err_q <= 1'b0;
            end else if (reject) begin
                bin_q  <= '0;
                err_q  <= 1'b1;
                done_q <= 1'b1;
            end else if (state_q == CONV) begin
                acc_q <= acc_nxt;
                if (last) begin
                    bin_q  <= acc_nxt;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign bin  = bin_q;

endmodule
